// File: rtl/riskbes_pkg.sv
// Shared pipeline definitions: data widths, writeback source select codes,
// the long-unit result record and the writeback source mux.
package riskbes_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_LOAD = 2'b01,
    WB_SEL_IMM  = 2'b10,
    WB_SEL_PC4  = 2'b11
  } wb_sel_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } long_entry_t;

  function automatic logic [XLEN-1:0] wb_select(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] load,
    input logic [XLEN-1:0] imm,
    input logic [XLEN-1:0] pc
  );
    logic [XLEN-1:0] result;
    result = alu;
    case (wb_sel_e'(sel))
      WB_SEL_ALU:  result = alu;
      WB_SEL_LOAD: result = load;
      WB_SEL_IMM:  result = imm;
      WB_SEL_PC4:  result = pc + XLEN'(4);
    endcase
    return result;
  endfunction

endpackage

// File: rtl/wb_long_fifo.sv
// FIFO buffering long-unit results until the register-file port is free.
// Caller guarantees no push when full and no pop when empty.
module wb_long_fifo
  import riskbes_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  long_entry_t wdata,
  output long_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  long_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [CNT_W-1:0]  count;

  assign head  = mem[rptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects the pipeline result and arbitrates the single
// register-file write port with buffered long-unit results.
// Optional retired-write counter enabled by RISKBES_WB_COUNT_EN.
module writeback_stage
  import riskbes_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  busywait_i,
  input  logic                  reg_wb_en_i,
  input  logic [REG_ADDR_W-1:0] rd_label_i,
  input  logic [XLEN-1:0]       alu_out_i,
  input  logic [XLEN-1:0]       load_val_i,
  input  logic [1:0]            wb_sel_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic [XLEN-1:0]       pc_i,
  input  logic                  is_long_i,
  input  logic                  long_valid_i,
  input  logic [REG_ADDR_W-1:0] long_rd_i,
  input  logic [XLEN-1:0]       long_data_i,
  output logic                  long_ready_o,
  output logic                  rf_write_en_o,
  output logic [REG_ADDR_W-1:0] rf_rd_label_o,
  output logic [XLEN-1:0]       rf_write_data_o
`ifdef RISKBES_WB_COUNT_EN
  ,
  output logic [63:0]           wb_count_o
`endif
);

  logic            pw;
  logic            long_accept;
  logic            long_nonzero;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  long_entry_t     head;
  logic            wr_en;
  logic [REG_ADDR_W-1:0] wr_rd;
  logic [XLEN-1:0] wr_data;

  assign pw           = !busywait_i && reg_wb_en_i && !is_long_i && (rd_label_i != '0);
  assign long_ready_o = !full;
  assign long_accept  = long_valid_i && long_ready_o;
  assign long_nonzero = (long_rd_i != '0);
  assign bypass       = long_accept && long_nonzero && empty && !pw;
  assign push         = long_accept && long_nonzero && !bypass;
  assign pop          = !empty && !pw;

  wb_long_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .wdata ('{rd: long_rd_i, data: long_data_i}),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    wr_en   = 1'b0;
    wr_rd   = rd_label_i;
    wr_data = wb_select(wb_sel_i, alu_out_i, load_val_i, imm_i, pc_i);
    if (pw) begin
      wr_en = 1'b1;
    end else if (pop) begin
      wr_en   = 1'b1;
      wr_rd   = head.rd;
      wr_data = head.data;
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_rd   = long_rd_i;
      wr_data = long_data_i;
    end
  end

  // Address/data hold their last written values on idle cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rf_write_en_o   <= 1'b0;
      rf_rd_label_o   <= '0;
      rf_write_data_o <= '0;
    end else begin
      rf_write_en_o <= wr_en;
      if (wr_en) begin
        rf_rd_label_o   <= wr_rd;
        rf_write_data_o <= wr_data;
      end
    end
  end

`ifdef RISKBES_WB_COUNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_count_o <= '0;
    end else if (wr_en) begin
      wb_count_o <= wb_count_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: a queue-based reference model predicts
// every cycle's port state; a separate monitor pops and compares.
module tb_writeback_stage;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        busywait_i;
  logic        reg_wb_en_i;
  logic [4:0]  rd_label_i;
  logic [31:0] alu_out_i;
  logic [31:0] load_val_i;
  logic [1:0]  wb_sel_i;
  logic [31:0] imm_i;
  logic [31:0] pc_i;
  logic        is_long_i;
  logic        long_valid_i;
  logic [4:0]  long_rd_i;
  logic [31:0] long_data_i;
  logic        long_ready_o;
  logic        rf_write_en_o;
  logic [4:0]  rf_rd_label_o;
  logic [31:0] rf_write_data_o;
`ifdef RISKBES_WB_COUNT_EN
  logic [63:0] wb_count_o;
`endif

  always #5 clk = ~clk;

  writeback_stage #(
    .DEPTH (DEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .busywait_i      (busywait_i),
    .reg_wb_en_i     (reg_wb_en_i),
    .rd_label_i      (rd_label_i),
    .alu_out_i       (alu_out_i),
    .load_val_i      (load_val_i),
    .wb_sel_i        (wb_sel_i),
    .imm_i           (imm_i),
    .pc_i            (pc_i),
    .is_long_i       (is_long_i),
    .long_valid_i    (long_valid_i),
    .long_rd_i       (long_rd_i),
    .long_data_i     (long_data_i),
    .long_ready_o    (long_ready_o),
    .rf_write_en_o   (rf_write_en_o),
    .rf_rd_label_o   (rf_rd_label_o),
    .rf_write_data_o (rf_write_data_o)
`ifdef RISKBES_WB_COUNT_EN
    ,
    .wb_count_o      (wb_count_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        ready;
    logic [63:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [36:0] lbuf[$];
  logic [63:0] mcnt;
  logic        acc_flag = 1'b0;
  int          compared = 0;
  int          mismatched = 0;
  logic        mon_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue stands in for the long-result buffer.
  initial begin
    forever begin
      exp_t        e;
      logic        pw;
      logic        acc;
      logic        wrote;
      logic [31:0] pd;
      @(posedge clk);
      e.rst = rst_i; e.en = 1'b0; e.rd = 5'd0; e.data = 32'd0;
      acc = 1'b0;
      if (rst_i) begin
        lbuf.delete();
        mcnt = 64'd0;
      end else begin
        pw  = !busywait_i && reg_wb_en_i && !is_long_i && rd_label_i != 5'd0;
        acc = long_valid_i && (lbuf.size() < DEPTH);
        case (wb_sel_i)
          2'd0:    pd = alu_out_i;
          2'd1:    pd = load_val_i;
          2'd2:    pd = imm_i;
          default: pd = pc_i + 32'd4;
        endcase
        wrote = 1'b0;
        if (pw) begin
          e.en = 1'b1; e.rd = rd_label_i; e.data = pd;
        end else if (lbuf.size() != 0) begin
          logic [36:0] h;
          h = lbuf.pop_front();
          e.en = 1'b1; e.rd = h[36:32]; e.data = h[31:0];
        end else if (acc && long_rd_i != 5'd0) begin
          e.en = 1'b1; e.rd = long_rd_i; e.data = long_data_i;
          wrote = 1'b1;
        end
        if (acc && long_rd_i != 5'd0 && !wrote) lbuf.push_back({long_rd_i, long_data_i});
        if (e.en) mcnt = mcnt + 64'd1;
      end
      acc_flag = acc;
      e.ready  = (lbuf.size() != DEPTH);
      e.cnt    = mcnt;
      sb.push_back(e);
    end
  end

  // Monitor: compares the registered port state one step after each edge.
  initial begin
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    last_rd = 5'd0; last_data = 32'd0;
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", 64'd0, 64'd1);
      end else begin
        e = sb.pop_front();
        if (mon_on) begin
          if (e.rst) begin last_rd = 5'd0; last_data = 32'd0; end
          chk("wr_en", rf_write_en_o, e.en);
          chk("long_ready", long_ready_o, e.ready);
          if (e.en) begin
            chk("wr_rd", rf_rd_label_o, e.rd);
            chk("wr_data", rf_write_data_o, e.data);
            last_rd = e.rd; last_data = e.data;
          end else begin
            chk("hold_rd", rf_rd_label_o, last_rd);
            chk("hold_data", rf_write_data_o, last_data);
          end
`ifdef RISKBES_WB_COUNT_EN
          chk("wb_count", wb_count_o, e.cnt);
`endif
        end
      end
    end
  end

  task automatic idle();
    busywait_i = 1'b0; reg_wb_en_i = 1'b0; rd_label_i = 5'd0; is_long_i = 1'b0;
    alu_out_i = 32'd0; load_val_i = 32'd0; wb_sel_i = 2'd0; imm_i = 32'd0; pc_i = 32'd0;
    long_valid_i = 1'b0; long_rd_i = 5'd0; long_data_i = 32'd0;
  endtask

  initial begin
    logic got;
    rst_i = 1'b1;
    idle();
    @(negedge clk);
    mon_on = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;

    // pc+4 wraps to zero
    reg_wb_en_i = 1'b1; rd_label_i = 5'd5; wb_sel_i = 2'd3; pc_i = 32'hFFFF_FFFC;
    @(negedge clk); idle();

    // stalled instruction writes exactly once
    busywait_i = 1'b1; reg_wb_en_i = 1'b1; rd_label_i = 5'd7; alu_out_i = 32'h1234;
    repeat (3) @(negedge clk);
    busywait_i = 1'b0;
    @(negedge clk); idle();

    // bypass of a long result into an idle port
    long_valid_i = 1'b1; long_rd_i = 5'd9; long_data_i = 32'hDEAD;
    @(negedge clk); idle();
    @(negedge clk);

    // fill buffer under pipeline pressure, then hold C while full
    reg_wb_en_i = 1'b1; rd_label_i = 5'd1; alu_out_i = 32'h100;
    long_valid_i = 1'b1; long_rd_i = 5'd3; long_data_i = 32'hAAAA;
    @(negedge clk);
    alu_out_i = 32'h101; long_rd_i = 5'd4; long_data_i = 32'hBBBB;
    @(negedge clk);
    alu_out_i = 32'h102; long_rd_i = 5'd11; long_data_i = 32'hCCCC;
    repeat (2) @(negedge clk);
    reg_wb_en_i = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (acc_flag) begin got = 1'b1; break; end
    end
    chk("c_accepted", got, 1'b1);
    idle();
    repeat (3) @(negedge clk);

    // rd 0 long result dropped; reset discards a buffered entry
    long_valid_i = 1'b1; long_rd_i = 5'd0; long_data_i = 32'hFFFF;
    @(negedge clk);
    reg_wb_en_i = 1'b1; rd_label_i = 5'd2; alu_out_i = 32'h22;
    long_rd_i = 5'd10; long_data_i = 32'h1010;
    @(negedge clk);
    long_valid_i = 1'b0; rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; idle();
    repeat (4) @(negedge clk);

    // randomized traffic with a held-until-accepted long handshake
    for (int n = 0; n < 500; n++) begin
      busywait_i  = ($urandom_range(0, 3) == 0);
      reg_wb_en_i = $urandom_range(0, 1);
      rd_label_i  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      is_long_i   = ($urandom_range(0, 4) == 0);
      wb_sel_i    = 2'($urandom);
      alu_out_i   = $urandom;
      load_val_i  = $urandom;
      imm_i       = $urandom;
      pc_i        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      if (!long_valid_i || acc_flag) begin
        long_valid_i = $urandom_range(0, 1);
        long_rd_i    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        long_data_i  = $urandom;
      end
      rst_i = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst_i = 1'b0; idle();
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
